// File: rtl/ins_fetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
package ins_fetch_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } fetch_state_e;

  localparam int unsigned QUEUE_DEPTH = 2;
  localparam int unsigned CNT_WIDTH   = $clog2(QUEUE_DEPTH + 1);

endpackage : ins_fetch_pkg

// File: rtl/ins_fetch_fifo.sv
// Two-entry {pc, instruction} queue; entry 0 is always the head so outputs come straight from flops.
module ins_fetch_fifo
  import ins_fetch_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 12,
  parameter int unsigned ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rstN,
  input  logic                  push,
  input  logic                  pop,
  input  logic                  flush,
  input  logic [ADDR_WIDTH-1:0] push_pc,
  input  logic [DATA_WIDTH-1:0] push_ins,
  output logic [CNT_WIDTH-1:0]  count,
  output logic                  head_valid,
  output logic [ADDR_WIDTH-1:0] head_pc,
  output logic [DATA_WIDTH-1:0] head_ins
);

  logic [CNT_WIDTH-1:0]  count_q, count_d;
  logic [ADDR_WIDTH-1:0] pc_q  [QUEUE_DEPTH];
  logic [ADDR_WIDTH-1:0] pc_d  [QUEUE_DEPTH];
  logic [DATA_WIDTH-1:0] ins_q [QUEUE_DEPTH];
  logic [DATA_WIDTH-1:0] ins_d [QUEUE_DEPTH];

  // Shift-on-pop queue: a pop moves entry 1 into the head slot.
  always_comb begin
    count_d = count_q;
    pc_d    = pc_q;
    ins_d   = ins_q;
    if (flush) begin
      count_d = '0;
    end else if (push && pop) begin
      if (count_q == CNT_WIDTH'(QUEUE_DEPTH)) begin
        pc_d[0]  = pc_q[1];
        ins_d[0] = ins_q[1];
        pc_d[1]  = push_pc;
        ins_d[1] = push_ins;
      end else begin
        pc_d[0]  = push_pc;
        ins_d[0] = push_ins;
      end
    end else if (push) begin
      pc_d[count_q[0]]  = push_pc;
      ins_d[count_q[0]] = push_ins;
      count_d           = count_q + CNT_WIDTH'(1);
    end else if (pop) begin
      pc_d[0]  = pc_q[1];
      ins_d[0] = ins_q[1];
      count_d  = count_q - CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      count_q <= '0;
      for (int i = 0; i < QUEUE_DEPTH; i++) begin
        pc_q[i]  <= '0;
        ins_q[i] <= '0;
      end
    end else begin
      count_q <= count_d;
      pc_q    <= pc_d;
      ins_q   <= ins_d;
    end
  end

  assign count      = count_q;
  assign head_valid = (count_q != '0);
  assign head_pc    = pc_q[0];
  assign head_ins   = ins_q[0];

  // The issue rule upstream must keep the queue from overflowing.
  overflow_a : assert property (@(posedge clk) disable iff (!rstN)
    !(push && !pop && !flush && count_q == CNT_WIDTH'(QUEUE_DEPTH)));

  underflow_a : assert property (@(posedge clk) disable iff (!rstN)
    !(pop && !flush && count_q == '0));

endmodule : ins_fetch_fifo

// File: rtl/ins_fetch.sv
// Instruction fetch unit: issues reads to a 1-cycle-latency memory and buffers returns for decode.
module ins_fetch
  import ins_fetch_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 12,
  parameter int unsigned DEPTH      = 256,
  parameter int unsigned ADDR_WIDTH = $clog2(DEPTH),
  parameter int unsigned START_ADDR = 0
) (
  input  logic                  clk,
  input  logic                  rstN,
  input  logic                  start,
  input  logic                  stop,
  input  logic                  jumpEn,
  input  logic [ADDR_WIDTH-1:0] jumpAddr,
  output logic [ADDR_WIDTH-1:0] memAddr,
  input  logic [DATA_WIDTH-1:0] memData,
  output logic [DATA_WIDTH-1:0] insOut,
  output logic [ADDR_WIDTH-1:0] insPc,
  output logic                  insValid,
  input  logic                  insReady,
  output logic                  busy
);

  fetch_state_e          state_q, state_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [ADDR_WIDTH-1:0] issued_addr_q, issued_addr_d;
  logic                  pending_q, pending_d;
  logic                  push, pop, flush, fire, issue;
  logic [CNT_WIDTH-1:0]  fifo_count;
  logic [CNT_WIDTH:0]    occupancy;

  assign fire      = insValid && insReady && (state_q == RUN);
  assign occupancy = (CNT_WIDTH+1)'(fifo_count) + (CNT_WIDTH+1)'(pending_q)
                   - (CNT_WIDTH+1)'(fire);
  assign issue     = (occupancy < (CNT_WIDTH+1)'(QUEUE_DEPTH));

  // Next-state: stop beats jump beats normal issue/return.
  always_comb begin
    state_d       = state_q;
    mem_addr_d    = mem_addr_q;
    issued_addr_d = issued_addr_q;
    pending_d     = 1'b0;
    push          = 1'b0;
    pop           = 1'b0;
    flush         = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d    = RUN;
          mem_addr_d = ADDR_WIDTH'(START_ADDR);
        end
      end
      RUN: begin
        if (stop) begin
          state_d = IDLE;
          flush   = 1'b1;
        end else if (jumpEn) begin
          flush      = 1'b1;
          mem_addr_d = jumpAddr;
        end else begin
          push = pending_q;
          pop  = fire;
          if (issue) begin
            pending_d     = 1'b1;
            issued_addr_d = mem_addr_q;
            mem_addr_d    = mem_addr_q + ADDR_WIDTH'(1);
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state_q       <= IDLE;
      mem_addr_q    <= ADDR_WIDTH'(START_ADDR);
      issued_addr_q <= '0;
      pending_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      mem_addr_q    <= mem_addr_d;
      issued_addr_q <= issued_addr_d;
      pending_q     <= pending_d;
    end
  end

  ins_fetch_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_fifo (
    .clk        (clk),
    .rstN       (rstN),
    .push       (push),
    .pop        (pop),
    .flush      (flush),
    .push_pc    (issued_addr_q),
    .push_ins   (memData),
    .count      (fifo_count),
    .head_valid (insValid),
    .head_pc    (insPc),
    .head_ins   (insOut)
  );

  assign memAddr = mem_addr_q;
  assign busy    = (state_q == RUN);

endmodule : ins_fetch

// File: tb/tb_ins_fetch.sv
// Self-checking bench for ins_fetch: expected stream is pc-ordered words from a preloaded memory.
module tb_ins_fetch;

  localparam int unsigned DW    = 12;
  localparam int unsigned DEPTH = 256;
  localparam int unsigned AW    = 8;

  logic          clk = 1'b0;
  logic          rstN, start, stop, jumpEn, insReady;
  logic [AW-1:0] jumpAddr, memAddr, insPc;
  logic [DW-1:0] memData, insOut;
  logic          insValid, busy;

  logic [DW-1:0] mem [DEPTH];
  int            checks = 0;
  int            errors = 0;
  logic [AW-1:0] exp_pc;

  ins_fetch #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .ADDR_WIDTH(AW), .START_ADDR(0)) dut (
    .clk(clk), .rstN(rstN), .start(start), .stop(stop), .jumpEn(jumpEn),
    .jumpAddr(jumpAddr), .memAddr(memAddr), .memData(memData), .insOut(insOut),
    .insPc(insPc), .insValid(insValid), .insReady(insReady), .busy(busy)
  );

  always #5 clk = ~clk;

  // Synchronous-read instruction memory, one cycle of latency.
  always @(posedge clk) memData <= mem[memAddr];

  function automatic logic [DW-1:0] word_at(input logic [AW-1:0] pc);
    return DW'(12'h100 + DW'(pc));
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rstN = 1'b0; start = 1'b0; stop = 1'b0; jumpEn = 1'b0; jumpAddr = '0; insReady = 1'b0;
    repeat (2) tick();
    checks++; if (insValid !== 1'b0) begin errors++; $display("FAIL reset_valid got %0b want 0", insValid); end
    checks++; if (insOut !== 12'h000) begin errors++; $display("FAIL reset_insOut got %h want 000", insOut); end
    checks++; if (insPc !== 8'h00) begin errors++; $display("FAIL reset_insPc got %h want 00", insPc); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %0b want 0", busy); end
    checks++; if (memAddr !== 8'h00) begin errors++; $display("FAIL reset_memAddr got %h want 00", memAddr); end
    rstN = 1'b1;
    repeat (2) tick();
    checks++; if (busy !== 1'b0 || insValid !== 1'b0) begin errors++; $display("FAIL idle_after_reset got busy=%0b valid=%0b want 0/0", busy, insValid); end
  endtask

  task automatic test_start;
    insReady = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    checks++; if (busy !== 1'b1 || insValid !== 1'b0 || memAddr !== 8'h00) begin
      errors++; $display("FAIL start_edge got busy=%0b valid=%0b addr=%h want 1/0/00", busy, insValid, memAddr); end
    tick();
    checks++; if (insValid !== 1'b0 || memAddr !== 8'h01) begin
      errors++; $display("FAIL issue_edge got valid=%0b addr=%h want 0/01", insValid, memAddr); end
    tick();
    exp_pc = 8'h00;
    for (int i = 0; i < 3; i++) begin
      checks++; if (insValid !== 1'b1 || insPc !== exp_pc || insOut !== word_at(exp_pc)) begin
        errors++; $display("FAIL start_stream got v=%0b pc=%h ins=%h want 1/%h/%h", insValid, insPc, insOut, exp_pc, word_at(exp_pc)); end
      exp_pc++;
      tick();
    end
  endtask

  task automatic test_stall;
    insReady = 1'b0;
    for (int i = 0; i < 6; i++) begin
      checks++; if (insValid !== 1'b1 || insPc !== exp_pc || insOut !== word_at(exp_pc)) begin
        errors++; $display("FAIL stall_hold got v=%0b pc=%h ins=%h want 1/%h/%h", insValid, insPc, insOut, exp_pc, word_at(exp_pc)); end
      checks++; if (memAddr !== AW'(exp_pc + 8'd2)) begin
        errors++; $display("FAIL stall_addr got %h want %h", memAddr, AW'(exp_pc + 8'd2)); end
      tick();
    end
    insReady = 1'b1;
    for (int i = 0; i < 3; i++) begin
      checks++; if (insValid !== 1'b1 || insPc !== exp_pc || insOut !== word_at(exp_pc)) begin
        errors++; $display("FAIL stall_resume got v=%0b pc=%h ins=%h want 1/%h/%h", insValid, insPc, insOut, exp_pc, word_at(exp_pc)); end
      exp_pc++;
      tick();
    end
  endtask

  task automatic test_random_stream;
    logic          prev_stall = 1'b0;
    logic [AW-1:0] prev_pc = '0;
    logic [DW-1:0] prev_ins = '0;
    int            fires = 0;
    for (int i = 0; i < 400; i++) begin
      insReady = ($urandom_range(0, 3) != 0);
      if (prev_stall) begin
        checks++; if (insValid !== 1'b1 || insPc !== prev_pc || insOut !== prev_ins) begin
          errors++; $display("FAIL rand_hold got v=%0b pc=%h ins=%h want 1/%h/%h", insValid, insPc, insOut, prev_pc, prev_ins); end
      end
      if (insValid && insReady) begin
        checks++; if (insPc !== exp_pc || insOut !== word_at(exp_pc)) begin
          errors++; $display("FAIL rand_order got pc=%h ins=%h want %h/%h", insPc, insOut, exp_pc, word_at(exp_pc)); end
        exp_pc++;
        fires++;
      end
      prev_stall = insValid && !insReady;
      prev_pc    = insPc;
      prev_ins   = insOut;
      tick();
    end
    checks++; if (fires < 200) begin errors++; $display("FAIL rand_throughput got %0d fires want >=200", fires); end
  endtask

  task automatic test_jump;
    int waited;
    insReady = 1'b1;
    repeat (3) begin
      if (insValid) exp_pc++;
      tick();
    end
    jumpEn = 1'b1; jumpAddr = 8'h40;
    tick();
    jumpEn = 1'b0;
    checks++; if (insValid !== 1'b0 || memAddr !== 8'h40) begin
      errors++; $display("FAIL jump_edge got v=%0b addr=%h want 0/40", insValid, memAddr); end
    tick();
    checks++; if (insValid !== 1'b0) begin errors++; $display("FAIL jump_gap got v=%0b want 0", insValid); end
    tick();
    exp_pc = 8'h40;
    for (int i = 0; i < 3; i++) begin
      checks++; if (insValid !== 1'b1 || insPc !== exp_pc || insOut !== word_at(exp_pc)) begin
        errors++; $display("FAIL jump_stream got v=%0b pc=%h ins=%h want 1/%h/%h", insValid, insPc, insOut, exp_pc, word_at(exp_pc)); end
      exp_pc++;
      tick();
    end
    // Back-to-back jumps from a full queue: the second target must win.
    insReady = 1'b0;
    repeat (3) tick();
    jumpEn = 1'b1; jumpAddr = 8'h10;
    tick();
    jumpAddr = 8'h20;
    tick();
    jumpEn = 1'b0; insReady = 1'b1;
    waited = 0;
    while (!insValid && waited < 8) begin tick(); waited++; end
    checks++; if (waited != 2) begin errors++; $display("FAIL b2b_latency got %0d want 2", waited); end
    checks++; if (insValid !== 1'b1 || insPc !== 8'h20 || insOut !== 12'h120) begin
      errors++; $display("FAIL b2b_target got v=%0b pc=%h ins=%h want 1/20/120", insValid, insPc, insOut); end
    exp_pc = 8'h21;
    tick();
  endtask

  task automatic test_wrap;
    int waited;
    insReady = 1'b1;
    jumpEn = 1'b1; jumpAddr = 8'hFE;
    tick();
    jumpEn = 1'b0;
    waited = 0;
    while (!insValid && waited < 8) begin tick(); waited++; end
    checks++; if (waited != 2) begin errors++; $display("FAIL wrap_latency got %0d want 2", waited); end
    exp_pc = 8'hFE;
    for (int i = 0; i < 4; i++) begin
      checks++; if (insValid !== 1'b1 || insPc !== exp_pc || insOut !== word_at(exp_pc)) begin
        errors++; $display("FAIL wrap_stream got v=%0b pc=%h ins=%h want 1/%h/%h", insValid, insPc, insOut, exp_pc, word_at(exp_pc)); end
      exp_pc++;
      tick();
    end
  endtask

  task automatic test_stop;
    logic [AW-1:0] frozen;
    insReady = 1'b1;
    stop = 1'b1;
    tick();
    stop = 1'b0;
    checks++; if (insValid !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL stop_edge got v=%0b busy=%0b want 0/0", insValid, busy); end
    frozen = memAddr;
    repeat (4) tick();
    checks++; if (memAddr !== frozen || insValid !== 1'b0) begin
      errors++; $display("FAIL stop_frozen got addr=%h v=%0b want %h/0", memAddr, insValid, frozen); end
    start = 1'b1;
    tick();
    start = 1'b0;
    checks++; if (memAddr !== 8'h00 || busy !== 1'b1) begin
      errors++; $display("FAIL restart_addr got addr=%h busy=%0b want 00/1", memAddr, busy); end
    repeat (2) tick();
    checks++; if (insValid !== 1'b1 || insPc !== 8'h00 || insOut !== 12'h100) begin
      errors++; $display("FAIL restart_first got v=%0b pc=%h ins=%h want 1/00/100", insValid, insPc, insOut); end
    repeat (3) tick();
  endtask

  task automatic test_async_reset;
    checks++; if (insValid !== 1'b1) begin errors++; $display("FAIL pre_reset_stream got v=%0b want 1", insValid); end
    #3;
    rstN = 1'b0;
    #1;
    checks++; if (insValid !== 1'b0 || insOut !== 12'h000 || insPc !== 8'h00 || busy !== 1'b0 || memAddr !== 8'h00) begin
      errors++; $display("FAIL async_reset got v=%0b ins=%h pc=%h busy=%0b addr=%h want 0/000/00/0/00",
                         insValid, insOut, insPc, busy, memAddr); end
    tick();
    rstN = 1'b1;
    jumpEn = 1'b1; jumpAddr = 8'h55;
    tick();
    jumpEn = 1'b0;
    checks++; if (memAddr !== 8'h00 || busy !== 1'b0 || insValid !== 1'b0) begin
      errors++; $display("FAIL idle_jump got addr=%h busy=%0b v=%0b want 00/0/0", memAddr, busy, insValid); end
    repeat (3) tick();
    checks++; if (insValid !== 1'b0 || memAddr !== 8'h00) begin
      errors++; $display("FAIL idle_quiet got v=%0b addr=%h want 0/00", insValid, memAddr); end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout simulation did not complete");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < DEPTH; i++) mem[i] = DW'(12'h100 + i);
    test_reset();
    test_start();
    test_stall();
    test_random_stream();
    test_jump();
    test_wrap();
    test_stop();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_ins_fetch
